// File: rtl/fir_pkg.sv
// Shared types and constant helpers for the FirFilter output path.
// Covers the rounding mode encoding, the rounded width and the signed saturation limits.
package fir_pkg;

    typedef enum logic [1:0] {
        TRUNC      = 2'd0,
        HALF_UP    = 2'd1,
        CONVERGENT = 2'd2
    } round_mode_e;

    // One extra bit keeps the rounding carry from wrapping.
    function automatic int rnd_width(input int iw, input int sh);
        return iw - sh + 1;
    endfunction

    function automatic longint sat_max(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational rounding (din -> o_rnd) and saturation (i_rnd -> o_dat/o_sat), split so a register can sit between.
// Zero latency, no flow control.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT        = 8,
    parameter int ROUND_MODE   = 2
) (
    input  logic [INPUT_WIDTH-1:0]                         i_din,
    output logic [rnd_width(INPUT_WIDTH, SHIFT)-1:0]       o_rnd,
    input  logic signed [rnd_width(INPUT_WIDTH, SHIFT)-1:0] i_rnd,
    output logic [OUTPUT_WIDTH-1:0]                        o_dat,
    output logic                                           o_sat
);
    localparam int XW = INPUT_WIDTH + 1;
    localparam logic [XW-1:0] HALF = XW'(1) << (SHIFT - 1);
    localparam longint MAXV = sat_max(OUTPUT_WIDTH);
    localparam longint MINV = sat_min(OUTPUT_WIDTH);

    logic [XW-1:0]    w_x;
    logic [XW-1:0]    w_sum;
    logic [SHIFT-1:0] w_unused_lsb;

    assign w_x = {i_din[INPUT_WIDTH-1], i_din};

    // Convergent adds half-minus-one plus the LSB that survives the shift, so ties land on even.
    always_comb begin
        w_sum = w_x;
        if (ROUND_MODE == int'(HALF_UP)) begin
            w_sum = w_x + HALF;
        end else if (ROUND_MODE == int'(CONVERGENT)) begin
            w_sum = w_x + HALF - XW'(1) + XW'(i_din[SHIFT]);
        end
    end

    assign o_rnd        = w_sum[XW-1:SHIFT];
    assign w_unused_lsb = w_sum[SHIFT-1:0];

    always_comb begin
        o_sat = 1'b0;
        o_dat = i_rnd[OUTPUT_WIDTH-1:0];
        if (longint'(i_rnd) > MAXV) begin
            o_sat = 1'b1;
            o_dat = OUTPUT_WIDTH'(MAXV);
        end else if (longint'(i_rnd) < MINV) begin
            o_sat = 1'b1;
            o_dat = OUTPUT_WIDTH'(MINV);
        end
    end

endmodule

// File: rtl/fir_round_decim.sv
// Decimate, round and saturate the wide FirFilter output into a narrow registered stream with saturation monitoring.
// Latency 2 cycles from kept valid_in to valid_out; no backpressure, one sample per cycle accepted.
module fir_round_decim
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH   = 26,
    parameter int OUTPUT_WIDTH  = 16,
    parameter int SHIFT         = 8,
    parameter int DECIM         = 4,
    parameter int PHASE         = 0,
    parameter int ROUND_MODE    = 2,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [INPUT_WIDTH-1:0]   din,
    input  logic                     sync,
    input  logic                     clr_flags,
    output logic                     valid_out,
    output logic [OUTPUT_WIDTH-1:0]  dout,
    output logic                     sat_flag,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);
    localparam int RW = rnd_width(INPUT_WIDTH, SHIFT);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] PH   = CW'(PHASE);
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);
    localparam logic [SAT_CNT_WIDTH-1:0] CNT_MAX = '1;

    if (SHIFT < 1 || SHIFT > INPUT_WIDTH - OUTPUT_WIDTH) begin : g_bad_shift
        $error("fir_round_decim: SHIFT out of range");
    end
    if (DECIM < 1) begin : g_bad_decim
        $error("fir_round_decim: DECIM must be >= 1");
    end
    if (PHASE < 0 || PHASE > DECIM - 1) begin : g_bad_phase
        $error("fir_round_decim: PHASE out of range");
    end
    if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_mode
        $error("fir_round_decim: ROUND_MODE out of range");
    end

    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              w_cnt_cur;
    logic [CW-1:0]              w_cnt_nxt;
    logic                       w_keep;
    logic                       r_s1_vld;
    logic signed [RW-1:0]       r_s1_rnd;
    logic [RW-1:0]              w_rnd;
    logic [OUTPUT_WIDTH-1:0]    w_sat_dat;
    logic                       w_sat;
    logic                       w_sat_evt;
    logic                       r_vld_out;
    logic [OUTPUT_WIDTH-1:0]    r_dout;
    logic                       r_sat_flag;
    logic [SAT_CNT_WIDTH-1:0]   r_sat_count;

    // sync forces the current sample to phase 0 before the keep decision.
    always_comb begin
        w_cnt_cur = sync ? '0 : r_cnt;
        w_keep    = valid_in && (w_cnt_cur == PH);
        w_cnt_nxt = r_cnt;
        if (valid_in) begin
            w_cnt_nxt = (w_cnt_cur == LAST) ? '0 : w_cnt_cur + CW'(1);
        end else if (sync) begin
            w_cnt_nxt = '0;
        end
    end

    fir_round_sat #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .SHIFT       (SHIFT),
        .ROUND_MODE  (ROUND_MODE)
    ) u_round_sat (
        .i_din(din),
        .o_rnd(w_rnd),
        .i_rnd(r_s1_rnd),
        .o_dat(w_sat_dat),
        .o_sat(w_sat)
    );

    assign w_sat_evt = r_s1_vld && w_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_rnd    <= '0;
            r_vld_out   <= 1'b0;
            r_dout      <= '0;
            r_sat_flag  <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_s1_vld  <= w_keep;
            r_vld_out <= r_s1_vld;
            if (w_keep) begin
                r_s1_rnd <= w_rnd;
            end
            if (r_s1_vld) begin
                r_dout <= w_sat_dat;
            end
            // A saturation event beats a simultaneous clear: it restarts the count at one.
            if (w_sat_evt) begin
                r_sat_flag <= 1'b1;
                if (clr_flags) begin
                    r_sat_count <= SAT_CNT_WIDTH'(1);
                end else if (r_sat_count != CNT_MAX) begin
                    r_sat_count <= r_sat_count + SAT_CNT_WIDTH'(1);
                end
            end else if (clr_flags) begin
                r_sat_flag  <= 1'b0;
                r_sat_count <= '0;
            end
        end
    end

    assign valid_out = r_vld_out;
    assign dout      = r_dout;
    assign sat_flag  = r_sat_flag;
    assign sat_count = r_sat_count;

endmodule

// File: tb/tb_fir_round_decim.sv
// Scoreboard bench: five fir_round_decim variants share one randomized stream, checked against an arithmetic model.
module tb_fir_round_decim;
    localparam int ND = 5;
    localparam int MODE_T [ND] = '{0, 1, 2, 2, 1};
    localparam int DEC_T  [ND] = '{1, 1, 1, 4, 3};
    localparam int PH_T   [ND] = '{0, 0, 0, 0, 2};
    localparam int CMAX_T [ND] = '{65535, 65535, 65535, 65535, 3};

    typedef struct {
        logic [15:0] val;
        bit          sat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, valid_in, sync, clr_flags;
    logic [25:0] din;
    logic        vo [ND];
    logic [15:0] dq [ND];
    logic        sf [ND];
    logic [15:0] sc [ND];
    logic [1:0]  sc4;

    exp_t        sb_q [ND][$];
    int          idx_m [ND];
    int          mcnt [ND];
    bit          mflag [ND];
    logic [15:0] last_m [ND];
    bit          hold_pend [ND];
    bit          pclr = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign sc[4] = {14'd0, sc4};

    fir_round_decim #(.DECIM(1), .ROUND_MODE(0)) u_d0 (.clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .sync(sync), .clr_flags(clr_flags), .valid_out(vo[0]), .dout(dq[0]), .sat_flag(sf[0]), .sat_count(sc[0]));
    fir_round_decim #(.DECIM(1), .ROUND_MODE(1)) u_d1 (.clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .sync(sync), .clr_flags(clr_flags), .valid_out(vo[1]), .dout(dq[1]), .sat_flag(sf[1]), .sat_count(sc[1]));
    fir_round_decim #(.DECIM(1), .ROUND_MODE(2)) u_d2 (.clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .sync(sync), .clr_flags(clr_flags), .valid_out(vo[2]), .dout(dq[2]), .sat_flag(sf[2]), .sat_count(sc[2]));
    fir_round_decim u_d3 (.clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .sync(sync), .clr_flags(clr_flags), .valid_out(vo[3]), .dout(dq[3]), .sat_flag(sf[3]), .sat_count(sc[3]));
    fir_round_decim #(.DECIM(3), .PHASE(2), .ROUND_MODE(1), .SAT_CNT_WIDTH(2)) u_d4 (.clk(clk), .rst(rst),
        .valid_in(valid_in), .din(din), .sync(sync), .clr_flags(clr_flags), .valid_out(vo[4]), .dout(dq[4]),
        .sat_flag(sf[4]), .sat_count(sc4));

    // Reference: floor-divide by 256, round from the remainder, then clamp to 16-bit signed.
    function automatic void ref_round(input longint x, input int mode, output logic [15:0] v, output bit s);
        longint q, r, y;
        q = x / 256;
        if ((x % 256) != 0 && x < 0) q = q - 1;
        r = x - q * 256;
        y = q;
        if (mode == 1 && r >= 128) y = q + 1;
        if (mode == 2 && (r > 128 || (r == 128 && (q % 2) != 0))) y = q + 1;
        s = 1'b0;
        if (y > 32767) begin
            y = 32767;
            s = 1'b1;
        end else if (y < -32768) begin
            y = -32768;
            s = 1'b1;
        end
        v = y[15:0];
    endfunction

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    task automatic step(input bit v, input longint x, input bit s, input bit c);
        int   k;
        exp_t ne;
        @(posedge clk);
        #1;
        valid_in  = v;
        din       = x[25:0];
        sync      = s;
        clr_flags = c;
        for (int d = 0; d < ND; d++) begin
            if (v) begin
                k = s ? 0 : idx_m[d];
                if ((k % DEC_T[d]) == PH_T[d]) begin
                    ref_round(x, MODE_T[d], ne.val, ne.sat);
                    ne.due = cyc + 2;
                    sb_q[d].push_back(ne);
                end
                idx_m[d] = k + 1;
            end else if (s) begin
                idx_m[d] = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0; sync = 1'b0; clr_flags = 1'b0; din = '0;
        for (int d = 0; d < ND; d++) begin
            sb_q[d].delete();
            idx_m[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst) begin
                chk("rst_valid_out", d, vo[d], 0);
                chk("rst_dout", d, dq[d], 0);
                chk("rst_sat_flag", d, sf[d], 0);
                chk("rst_sat_count", d, sc[d], 0);
                mflag[d] = 1'b0; mcnt[d] = 0; last_m[d] = '0; hold_pend[d] = 1'b0;
            end else if (vo[d]) begin
                if (sb_q[d].size() == 0) begin
                    chk("unexpected_valid_out", d, vo[d], 0);
                end else begin
                    e = sb_q[d].pop_front();
                    chk("dout", d, longint'($signed(dq[d])), longint'($signed(e.val)));
                    chk("latency", d, cyc, e.due);
                    last_m[d] = e.val;
                    if (e.sat) begin
                        mflag[d] = 1'b1;
                        mcnt[d]  = pclr ? 1 : ((mcnt[d] < CMAX_T[d]) ? mcnt[d] + 1 : mcnt[d]);
                    end else if (pclr) begin
                        mflag[d] = 1'b0; mcnt[d] = 0;
                    end
                    chk("sat_flag", d, sf[d], mflag[d]);
                    chk("sat_count", d, sc[d], mcnt[d]);
                end
                hold_pend[d] = 1'b1;
            end else begin
                if (hold_pend[d]) chk("dout_hold", d, dq[d], last_m[d]);
                hold_pend[d] = 1'b0;
                if (sb_q[d].size() > 0 && sb_q[d][0].due <= cyc) begin
                    chk("missing_valid_out", d, vo[d], 1);
                    void'(sb_q[d].pop_front());
                end
                if (pclr) begin
                    mflag[d] = 1'b0; mcnt[d] = 0;
                    chk("clr_sat_flag", d, sf[d], 0);
                    chk("clr_sat_count", d, sc[d], 0);
                end
            end
        end
        pclr = clr_flags && rst;
    end

    initial begin
        logic [25:0] rb;
        longint      x;
        int          sel;
        rst = 1'b0; valid_in = 1'b0; sync = 1'b0; clr_flags = 1'b0; din = '0;
        do_reset();

        // Rounding ties, saturation both ways, then a lone clear.
        step(1, 384, 0, 0);
        step(1, 128, 0, 0);
        step(1, 640, 0, 0);
        step(1, -128, 0, 0);
        step(1, 33554431, 0, 0);
        step(1, -33554432, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);

        do_reset();
        for (int k = 0; k < 16; k++) step(1, k * 256, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(1, k * 256, 0, 0);
            step(0, 0, 0, 0);
        end
        repeat (4) step(0, 0, 0, 0);

        do_reset();
        for (int k = 0; k < 16; k++) step(1, k * 256, (k == 6), 0);
        repeat (4) step(0, 0, 0, 0);

        do_reset();
        step(1, 2560, 0, 0);
        do_reset();
        repeat (4) step(0, 0, 0, 0);

        // Saturating kept sample whose output edge coincides with clr_flags.
        step(1, 33554431, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin rb = 26'($urandom); x = longint'($signed(rb)); end
                1: x = longint'($urandom_range(0, 8388607)) - 4194304;
                2: x = 32767 * 256 + 128 + longint'($urandom_range(0, 1023)) - 512;
                default: x = -32768 * 256 + longint'($urandom_range(0, 1023)) - 512;
            endcase
            step(($urandom_range(0, 3) != 0), x, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
        end
        repeat (6) step(0, 0, 0, 0);
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk("drain", d, sb_q[d].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_round_decim.md
Name: fir_round_decim

Overview:
- Output conditioning stage placed directly downstream of FirFilter.
- Consumes the wide full-precision filter output (valid_in/din) and keeps every DECIM-th valid sample.
- Rounds away SHIFT LSBs, saturates to OUTPUT_WIDTH and presents a registered, narrowed sample stream.
- Tracks saturation events in a sticky flag and a counter for software/monitoring.

Parameters:
- INPUT_WIDTH, 26, signed input sample width; matches FirFilter OUTPUT_WIDTH.
- OUTPUT_WIDTH, 16, signed output sample width.
- SHIFT, 8, number of LSBs discarded by rounding; legal range 1 <= SHIFT <= INPUT_WIDTH-OUTPUT_WIDTH.
- DECIM, 4, decimation factor; legal range >= 1; 1 = pass-through.
- PHASE, 0, index of the kept sample within each group of DECIM valid samples; legal range 0..DECIM-1.
- ROUND_MODE, 2, rounding mode: 0 truncate (floor), 1 round half up, 2 convergent (round half to even).
- SAT_CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- valid_in  input  1  din qualifier, one sample per cycle when high.
- din  input  INPUT_WIDTH  signed filter output sample.
- sync  input  1  single-cycle pulse that realigns the decimation phase.
- clr_flags  input  1  clears sat_flag and sat_count.
- valid_out  output  1  dout qualifier, single-cycle pulse per kept sample.
- dout  output  OUTPUT_WIDTH  signed rounded and saturated sample.
- sat_flag  output  1  sticky flag: at least one kept sample saturated.
- sat_count  output  SAT_CNT_WIDTH  count of saturated kept samples; holds at its maximum value.

Behaviour:
- Reset (rst low, asynchronous): valid_out=0, dout=0, sat_flag=0, sat_count=0, phase counter=0, all pipeline valids=0.
  - Reset mid-operation drops in-flight samples. No valid_out is issued for them after rst is released.
- Phase counter cnt (0..DECIM-1):
  - Advances only on cycles with valid_in=1 and wraps from DECIM-1 to 0.
  - A sample is kept when its cnt value equals PHASE.
  - Gaps (valid_in=0) do not advance cnt.
- sync handling:
  - sync=1 together with valid_in=1: that sample is treated as cnt=0 and cnt becomes 1 (mod DECIM).
  - sync=1 with valid_in=0: cnt is set to 0, so the next valid sample is cnt=0.
- Pipeline, latency fixed at 2 cycles from a kept valid_in to valid_out:
  - Stage 1 registers the rounded value, width INPUT_WIDTH-SHIFT+1 (the +1 prevents rounding overflow).
  - Stage 2 registers the saturated dout, valid_out and the flag updates.
  - No backpressure: the block accepts one sample per cycle indefinitely.
- Rounding of x = din (signed), t = x >>> SHIFT (arithmetic shift):
  - Mode 0: t.
  - Mode 1: (x + 2^(SHIFT-1)) >>> SHIFT.
  - Mode 2: (x + 2^(SHIFT-1) - 1 + x[SHIFT]) >>> SHIFT. Exact ties go to the even result.
- Saturation:
  - Rounded value > 2^(OUTPUT_WIDTH-1)-1 gives dout = max positive.
  - Rounded value < -2^(OUTPUT_WIDTH-1) gives dout = most negative.
- Saturation event (applied with valid_out): sat_flag set to 1; sat_count incremented, holding at 2^SAT_CNT_WIDTH-1.
- clr_flags:
  - Takes effect on the next clock edge.
  - If it coincides with a saturation event, the event wins: sat_flag=1, sat_count=1.
- dout holds its last value while valid_out=0.

Decomposition:
- fir_pkg holds:
  - a round_mode_e enum typedef (TRUNC, HALF_UP, CONVERGENT);
  - constant functions for the rounded width and the saturation limits, shared with FirFilter-related blocks.
- Sub-module fir_round_sat implements the combinational rounding and saturation with a sat indicator output. fir_round_decim instantiates it between the phase counter and the registers.
- The parameter legality checks sit in fir_round_decim as elaboration-time assertions.

Test Plan:
- Rounding (DECIM=1, defaults), output 2 cycles after input:
  - din=384 gives 2 in modes 1 and 2.
  - din=128 gives 1 in mode 1 and 0 in mode 2.
  - din=640 gives 3 in mode 1 and 2 in mode 2.
  - din=-128 gives -1 in mode 0 and 0 in mode 1.
- Saturation:
  - din=33554431 gives dout=0x7FFF, sat_flag=1, sat_count=1.
  - din=-33554432 gives dout=0x8000, sat_count=2.
  - Pulse clr_flags alone: both clear to 0.
- Decimation:
  - valid_in every cycle with din=k*256 for k=0..15 gives dout 0,4,8,12, each valid_out 2 cycles after its input.
  - valid_out is exactly 4 pulses, one every 4 cycles.
- Gapped input and sync:
  - valid_in alternating 1/0 with the same ramp gives the same values 0,4,8,12, spaced 8 cycles apart.
  - sync asserted with sample k=6 gives next outputs 6,10,14.
- Reset mid-stream and clr_flags coincidence:
  - rst low one cycle after a kept sample enters gives no valid_out for it; all outputs are 0.
  - clr_flags coinciding with a saturating kept sample gives sat_flag=1, sat_count=1.
